// File: rtl/detector_scan_sched_pkg.sv
// Shared types and helpers for the detector scan scheduler.
package det_sched_pkg;

  // Word-processing phases, in the order a granted word walks through them.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    REPORT
  } state_t;

  // Index width for n items; never below one bit so that n == 1 still gives a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/detector_scan_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or after the pointer wins, pointer moves past the winner.
module rr_arbiter
  import det_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2_min1(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic [IDW-1:0] ptr;

  // Two passes: requests at or above the pointer first, then the wrapped-around ones below it.
  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        id       = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i < int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        id       = IDW'(i);
      end
    end
  end

  // Pointer lands just after the winner so the winner has lowest priority on the next round.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    end
  end

endmodule

// File: rtl/detector_scan_sched.sv
// Time-shares one serial Moore pattern detector among NREQ requesters and counts its 0->1 output edges per word.
module detector_scan_sched
  import det_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*WIDTH-1:0]       data,
  output logic [NREQ-1:0]             gnt,
  output logic                        busy,
  output logic                        det_clr,
  output logic                        det_in,
  input  logic                        det_out,
  output logic                        done,
  output logic [clog2_min1(NREQ)-1:0] done_id,
  output logic [CNTW-1:0]             hit_cnt
);

  localparam int IDW = clog2_min1(NREQ);
  localparam int BIW = clog2_min1(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [NREQ-1:0]  arb_grant;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;
  logic             advance;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shreg;
  logic [BIW-1:0]   bit_idx;
  logic [IDW-1:0]   cur_id;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_next;
  logic             prev;
  logic             sample_en;
  logic             hit;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .advance (advance),
    .grant   (arb_grant),
    .id      (arb_id),
    .any     (arb_any)
  );

  // Pick out the winner's data slice so it can be latched in the arbitration cycle.
  always_comb begin
    word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) word = data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state logic; the arbiter pointer only moves when a word is actually accepted.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          state_next = CLEAR;
          advance    = 1'b1;
        end
      end
      CLEAR:  state_next = SHIFT;
      SHIFT:  if (bit_idx == BIW'(WIDTH - 1)) state_next = DRAIN;
      DRAIN:  state_next = REPORT;
      REPORT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered one cycle behind the state, and the detector adds one more cycle,
  // so det_out for bit j shows up two states after bit j is shifted: SHIFT index 2.. , DRAIN, REPORT.
  always_comb begin
    sample_en = 1'b0;
    case (state)
      SHIFT:         sample_en = (int'(bit_idx) >= 2);
      DRAIN, REPORT: sample_en = 1'b1;
      default:       sample_en = 1'b0;
    endcase
    hit      = sample_en && det_out && !prev;
    cnt_next = (hit && (cnt != '1)) ? cnt + 1'b1 : cnt;
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Word datapath: latch on grant, shift MSB first, accumulate rising edges of the detector output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg   <= '0;
      bit_idx <= '0;
      cur_id  <= '0;
      cnt     <= '0;
      prev    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            shreg   <= word;
            cur_id  <= arb_id;
            bit_idx <= '0;
          end
        end
        CLEAR: begin
          cnt  <= '0;
          prev <= 1'b0;
        end
        SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_idx <= bit_idx + 1'b1;
        end
        default: ;
      endcase
      if (sample_en) begin
        cnt  <= cnt_next;
        prev <= det_out;
      end
    end
  end

  // Registered outputs; the result registers pick up the final sample taken in REPORT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gnt     <= '0;
      busy    <= 1'b0;
      det_clr <= 1'b0;
      det_in  <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      hit_cnt <= '0;
    end else begin
      gnt     <= (state == IDLE) ? arb_grant : '0;
      busy    <= (state != IDLE);
      det_clr <= (state == CLEAR);
      det_in  <= (state == SHIFT) && shreg[WIDTH-1];
      done    <= (state == REPORT);
      if (state == REPORT) begin
        done_id <= cur_id;
        hit_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_detector_scan_sched.sv
// Self-checking bench: behavioural detector model, scoreboard of expected results, vector table plus corner sequences.
module tb_detector_scan_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;
  localparam int LAT   = WIDTH + 3;

  typedef enum logic [1:0] {D_START, D_ONE, D_HIT} dstate_t;
  typedef struct { int id; int cnt; int due; } exp_t;
  typedef struct { int id; logic [7:0] word; int cnt; } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  gnt;
  logic        busy, det_clr, det_in, det_out, done;
  logic [1:0]  done_id;
  logic [3:0]  hit_cnt;

  logic [3:0]  req2 = '0;
  logic [31:0] data2 = '0;
  logic [3:0]  gnt2;
  logic        busy2, clr2, din2, dout2, done2;
  logic [1:0]  done_id2;
  logic [0:0]  hit2;

  dstate_t ds  = D_START;
  dstate_t ds2 = D_START;
  exp_t    sb[$];
  exp_t    e;
  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  int      gnt_cnt  = 0;
  int      clr_cnt  = 0;
  int      last_id  = 0;
  int      last_cnt = 0;
  bit      busy_chk = 1'b0;

  detector_scan_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .det_clr(det_clr), .det_in(det_in), .det_out(det_out), .done(done),
    .done_id(done_id), .hit_cnt(hit_cnt)
  );

  detector_scan_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(1)) dut_sat (
    .CLK(CLK), .RST(RST), .req(req2), .data(data2), .gnt(gnt2), .busy(busy2),
    .det_clr(clr2), .det_in(din2), .det_out(dout2), .done(done2),
    .done_id(done_id2), .hit_cnt(hit2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Detector: 1 enters ONE, 0 from ONE enters HIT, 1 from HIT returns to START, otherwise stay.
  function automatic dstate_t det_next(input dstate_t s, input logic b);
    case (s)
      D_START: return b ? D_ONE : D_START;
      D_ONE:   return b ? D_ONE : D_HIT;
      default: return b ? D_START : D_HIT;
    endcase
  endfunction

  always @(posedge CLK) begin
    ds  <= det_clr ? D_START : det_next(ds, det_in);
    ds2 <= clr2 ? D_START : det_next(ds2, din2);
  end
  assign det_out = (ds == D_HIT);
  assign dout2   = (ds2 == D_HIT);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Scoreboard side: every done must match the oldest outstanding word in id, count and timing.
  always @(negedge CLK) begin
    if (RST) begin
      if (busy_chk) begin
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        busy_chk = 1'b0;
      end
      if (gnt != '0) begin
        gnt_cnt++;
        checkOutput("gnt_while_busy", 32'(busy), 32'd0);
      end
      if (det_clr) clr_cnt++;
      if (done) begin
        checkOutput("busy_at_done", 32'(busy), 32'd1);
        busy_chk = 1'b1;
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_id", 32'(done_id), e.id);
          checkOutput("hit_cnt", 32'(hit_cnt), e.cnt);
          checkOutput("done_latency", cyc, e.due);
          last_id  = e.id;
          last_cnt = e.cnt;
        end
      end
    end
  end

  task automatic applyStimulus(input int id, input logic [7:0] word, input int cnt);
    bit seen = 1'b0;
    @(negedge CLK);
    data = (data & ~(32'hFF << (id * 8))) | (32'(word) << (id * 8));
    req  = req | (4'b0001 << id);
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge CLK);
      if (gnt != '0) seen = 1'b1;
    end
    checkOutput("gnt_onehot", 32'(gnt), 32'(4'b0001 << id));
    if (seen) sb.push_back('{id, cnt, cyc + LAT});
    req = req & ~(4'b0001 << id);
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 40 && (sb.size() != 0 || busy); k++) @(negedge CLK);
    checkOutput("done_arrived", 32'(sb.size()), 32'd0);
  endtask

  task automatic waitGnt(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge CLK);
      if (gnt != '0) seen = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs [11];
    int   ord  [5];
    int   cnts [4];
    int   ng;
    int   gcyc;
    bit   seen;

    vecs = '{'{2, 8'hC0, 1}, '{1, 8'h00, 0}, '{3, 8'hFF, 0}, '{0, 8'h55, 2},
             '{2, 8'h92, 2}, '{1, 8'hA5, 2}, '{3, 8'h02, 1}, '{0, 8'h80, 1},
             '{1, 8'hCC, 2}, '{2, 8'h88, 1}, '{3, 8'h44, 1}};
    ord  = '{0, 1, 2, 3, 0};
    cnts = '{2, 1, 0, 0};
    gcyc = 0;

    // Reset state
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_outputs", 32'({gnt, busy, det_clr, det_in, done, done_id, hit_cnt}), 32'd0);
    checkOutput("reset_outputs_sat", 32'({gnt2, busy2, clr2, din2, done2, done_id2, hit2}), 32'd0);
    RST = 1'b1;

    // All four requesting: strict rotation starting from requester 0, 12 cycles per word
    @(negedge CLK);
    data = {8'hFF, 8'h00, 8'hC0, 8'hAA};
    req  = 4'b1111;
    ng   = 0;
    for (int k = 0; k < 100 && ng < 5; k++) begin
      @(negedge CLK);
      if (gnt != '0) begin
        checkOutput("rr_order", 32'(gnt), 32'(4'b0001 << ord[ng]));
        if (ng > 0) checkOutput("rr_spacing", cyc - gcyc, WIDTH + 4);
        gcyc = cyc;
        sb.push_back('{ord[ng], cnts[ord[ng]], cyc + LAT});
        ng++;
        if (ng == 5) req = '0;
      end
    end
    checkOutput("rr_grant_count", ng, 5);
    waitIdle();

    // Single word, then check results are held after done
    applyStimulus(0, 8'hAA, 2);
    waitIdle();
    repeat (3) @(negedge CLK);
    checkOutput("done_id_hold", 32'(done_id), last_id);
    checkOutput("hit_cnt_hold", 32'(hit_cnt), last_cnt);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].id, vecs[i].word, vecs[i].cnt);
      waitIdle();
    end

    // One-bit counter saturates
    @(negedge CLK);
    data2 = 32'h0000_00AA;
    req2  = 4'b0001;
    seen  = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge CLK);
      if (gnt2 != '0) seen = 1'b1;
    end
    checkOutput("sat_gnt", 32'(gnt2), 32'd1);
    req2 = '0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge CLK);
      if (done2) seen = 1'b1;
    end
    checkOutput("sat_done", 32'(done2), 32'd1);
    checkOutput("sat_hit_cnt", 32'(hit2), 32'd1);
    checkOutput("sat_done_id", 32'(done_id2), 32'd0);

    // Reset in the middle of a word: no done, pointer back to 0
    @(negedge CLK);
    data[15:8] = 8'hAA;
    req = 4'b0010;
    waitGnt(seen);
    checkOutput("pre_reset_gnt", 32'(gnt), 32'(4'b0010));
    req = '0;
    repeat (5) @(negedge CLK);
    req = 4'b0110;
    RST = 1'b0;
    #1;
    checkOutput("midword_reset_outputs", 32'({gnt, busy, det_clr, det_in, done, done_id, hit_cnt}), 32'd0);
    repeat (2) @(negedge CLK);
    checkOutput("reset_held_outputs", 32'({gnt, busy, det_clr, det_in, done, done_id, hit_cnt}), 32'd0);
    RST = 1'b1;
    waitGnt(seen);
    checkOutput("post_reset_gnt", 32'(gnt), 32'(4'b0010));
    if (seen) sb.push_back('{1, 2, cyc + LAT});
    req = '0;
    waitIdle();

    // Request and data churn while a word is in flight must not disturb it
    @(negedge CLK);
    data[23:16] = 8'h92;
    req = 4'b0100;
    waitGnt(seen);
    checkOutput("churn_gnt", 32'(gnt), 32'(4'b0100));
    if (seen) sb.push_back('{2, 2, cyc + LAT});
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      req         = 4'($urandom_range(0, 15));
      data[23:16] = 8'($urandom());
      checkOutput("gnt_outside_idle", 32'(gnt), 32'd0);
    end
    req = '0;
    waitIdle();
    repeat (3) @(negedge CLK);
    checkOutput("det_clr_per_word", clr_cnt, gnt_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
